fft_out_reorder_buffer: RTL



---
 rtl/fft_out_reorder_buffer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fft_out_reorder_buffer.sv
// Ping-pong reorder buffer: 8-sample beats land at natural-order addresses, full frames stream out one sample per cycle.
// Optional duplicate-index detection (dup_err port) is built when REORDER_DUP_CHECK_EN is defined.
module fft_out_reorder_buffer #(
  parameter int IDX_W = 11,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [4*DW-1:0]     in_col1_r,
  input  logic [4*DW-1:0]     in_col1_i,
  input  logic [4*DW-1:0]     in_col2_r,
  input  logic [4*DW-1:0]     in_col2_i,
  input  logic [IDX_W-1:0]    in_idx_col1,
  input  logic [IDX_W-1:0]    in_idx_col2,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DW-1:0]       m_data_r,
  output logic [DW-1:0]       m_data_i,
  output logic [IDX_W+1:0]    m_addr,
  output logic                m_last,
  output logic                overflow,
  output logic [15:0]         frame_cnt
`ifdef REORDER_DUP_CHECK_EN
  ,
  output logic                dup_err
`endif
);

  localparam int AW    = IDX_W + 2;
  localparam int DEPTH = 1 << AW;
  localparam int BW    = IDX_W - 1;

  typedef enum logic [1:0] {IDLE, READ, LAST} state_t;

  // Both banks share one array; the bank bit is the address MSB.
  logic [DW-1:0] mem_r [2*DEPTH];
  logic [DW-1:0] mem_i [2*DEPTH];

  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [BW-1:0] beat_cnt;
  logic [AW-1:0] rd_addr;
  state_t        state;

  logic wr_en;
  logic wr_last;
  logic advance;
  logic rd_done;

  assign wr_en   = in_valid && !full[wr_bank];
  assign wr_last = (beat_cnt == '1);
  assign advance = !m_valid || m_ready;
  assign rd_done = (state == LAST) && m_ready;

  // Write stage: col2 lanes are written after col1 so col2 wins on equal indices.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        mem_r[{wr_bank, in_idx_col1, 2'(k)}] <= in_col1_r[k*DW +: DW];
        mem_i[{wr_bank, in_idx_col1, 2'(k)}] <= in_col1_i[k*DW +: DW];
      end
      for (int k = 0; k < 4; k++) begin
        mem_r[{wr_bank, in_idx_col2, 2'(k)}] <= in_col2_r[k*DW +: DW];
        mem_i[{wr_bank, in_idx_col2, 2'(k)}] <= in_col2_i[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else if (in_valid) begin
      if (full[wr_bank]) begin
        overflow <= 1'b1;
      end else if (wr_last) begin
        wr_bank  <= ~wr_bank;
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // A bank freed by the reader is only seen as free by the writer on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_en && wr_last && (wr_bank == 1'(b)))
          full[b] <= 1'b1;
        else if (rd_done && (rd_bank == 1'(b)))
          full[b] <= 1'b0;
      end
    end
  end

  // Read stage: synchronous memory read straight into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_bank   <= 1'b0;
      rd_addr   <= '0;
      m_valid   <= 1'b0;
      m_data_r  <= '0;
      m_data_i  <= '0;
      m_addr    <= '0;
      m_last    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (full[rd_bank]) begin
            state   <= READ;
            rd_addr <= '0;
          end
        end
        READ: begin
          if (advance) begin
            m_valid  <= 1'b1;
            m_data_r <= mem_r[{rd_bank, rd_addr}];
            m_data_i <= mem_i[{rd_bank, rd_addr}];
            m_addr   <= rd_addr;
            m_last   <= (rd_addr == '1);
            if (rd_addr == '1)
              state <= LAST;
            else
              rd_addr <= rd_addr + 1'b1;
          end
        end
        LAST: begin
          if (m_ready) begin
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            rd_bank   <= ~rd_bank;
            rd_addr   <= '0;
            state     <= full[~rd_bank] ? READ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REORDER_DUP_CHECK_EN
  localparam int NCOL = 1 << IDX_W;

  logic [NCOL-1:0] bmap [2];

  // A bank's bitmap is wiped as the writer switches onto it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmap[0] <= '0;
      bmap[1] <= '0;
      dup_err <= 1'b0;
    end else if (wr_en) begin
      if (bmap[wr_bank][in_idx_col1] || bmap[wr_bank][in_idx_col2] ||
          (in_idx_col1 == in_idx_col2))
        dup_err <= 1'b1;
      bmap[wr_bank][in_idx_col1] <= 1'b1;
      bmap[wr_bank][in_idx_col2] <= 1'b1;
      if (wr_last)
        bmap[~wr_bank] <= '0;
    end
  end
`endif

endmodule
